// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back L1 data cache.
//  - Geometry: 32 lines x 256 bits, 32-bit byte addresses.
//  - Address split: tag = addr[31:10], idx = addr[9:5], word select = addr[4:2].
//  - FSM state encoding used by the controller and exposed on its debug port.
package dcache_pkg;

  localparam int NUM_LINES = 32;
  localparam int LINE_W    = 256;
  localparam int ADDR_W    = 32;
  localparam int WORD_W    = 32;
  localparam int OFF_W     = 5;
  localparam int WSEL_W    = 3;
  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int TAG_W     = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_REFILL    = 2'd3
  } state_t;

  // Line-aligned byte address built from a tag and an index.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_mem_if.sv
// Line-wide handshake between the cache controller and off-chip data memory.
//  enable : request valid, held stable by the master until ack
//  write  : 1 = line write-back, 0 = line fetch
//  addr   : line-aligned byte address (bits [4:0] = 0)
//  wdata  : victim line for a write-back
//  rdata  : fetched line, valid in the ack cycle
//  ack    : one-cycle completion pulse from memory
// Handshake: a request is in flight while enable=1; the memory completes it
// with a single-cycle ack, and the master changes or drops the request only
// in the cycle after the ack.
interface dcache_mem_if;
  import dcache_pkg::*;

  logic              enable;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              ack;

  modport master (output enable, write, addr, wdata, input rdata, ack);
  modport slave  (input enable, write, addr, wdata, output rdata, ack);

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and data storage for the direct-mapped cache.
//  Ports:
//   clk_i, rst_i     clock, asynchronous active-low reset (valid/dirty only)
//   rd_idx_i         read index; rd_* outputs are asynchronous reads
//   wr_en_i          write strobe for the single write port
//   wr_fill_i        1 = full-line fill (valid=1, dirty=0, tag updated)
//                    0 = word merge into the line (dirty=1)
//   wr_idx_i, wr_tag_i, wr_line_i, wr_wsel_i, wr_word_i  write operands
module dcache_sram
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              wr_en_i,
  input  logic              wr_fill_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_line_i,
  input  logic [WSEL_W-1:0] wr_wsel_i,
  input  logic [WORD_W-1:0] wr_word_i
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  assign rd_valid_o = r_valid[rd_idx_i];
  assign rd_dirty_o = r_dirty[rd_idx_i];
  assign rd_tag_o   = r_tag[rd_idx_i];
  assign rd_line_o  = r_data[rd_idx_i];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (wr_en_i) begin
      if (wr_fill_i) begin
        r_valid[wr_idx_i] <= 1'b1;
        r_dirty[wr_idx_i] <= 1'b0;
      end else begin
        r_dirty[wr_idx_i] <= 1'b1;
      end
    end
  end

  // Tag and data carry no reset: valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      if (wr_fill_i) begin
        r_tag[wr_idx_i]  <= wr_tag_i;
        r_data[wr_idx_i] <= wr_line_i;
      end else begin
        r_data[wr_idx_i][{wr_wsel_i, 5'd0} +: WORD_W] <= wr_word_i;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller (MEM stage).
//  Ports:
//   clk_i, rst_i           clock, asynchronous active-low reset
//   p1_MemRead_i           load request from EX/MEM
//   p1_MemWrite_i          store request (wins when both are high)
//   p1_addr_i, p1_data_i   word-aligned byte address, store data
//   p1_data_o              load data, valid while p1_stall_o=0
//   p1_stall_o             pipeline-wide freeze
//   dbg_state_o            current FSM state
//   mem                    line handshake to data memory (master side)
//  Hits complete in zero stall cycles. A miss stalls in the same cycle,
//  optionally writes back the dirty victim, fetches the line, refills the
//  arrays, and then completes as an ordinary hit. CPU inputs are held by
//  the frozen pipeline, so the request is never latched here.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               p1_MemRead_i,
  input  logic               p1_MemWrite_i,
  input  logic [ADDR_W-1:0]  p1_addr_i,
  input  logic [WORD_W-1:0]  p1_data_i,
  output logic [WORD_W-1:0]  p1_data_o,
  output logic               p1_stall_o,
  output state_t             dbg_state_o,
  dcache_mem_if.master       mem
);

  state_t            r_state;
  logic              r_mem_enable;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_data;
  logic [LINE_W-1:0] r_line_buf;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [WSEL_W-1:0] w_wsel;
  logic              w_unused_addr_lsb;
  logic              w_vic_valid;
  logic              w_vic_dirty;
  logic [TAG_W-1:0]  w_vic_tag;
  logic [LINE_W-1:0] w_vic_line;
  logic              w_req;
  logic              w_hit;
  logic              w_idle;
  logic              w_wr_en;
  logic              w_wr_fill;
  logic [WORD_W-1:0] w_sel_word;

  assign w_tag             = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign w_idx             = p1_addr_i[OFF_W +: IDX_W];
  assign w_wsel            = p1_addr_i[2 +: WSEL_W];
  assign w_unused_addr_lsb = ^p1_addr_i[1:0];

  assign w_req  = p1_MemRead_i | p1_MemWrite_i;
  assign w_hit  = w_vic_valid & (w_vic_tag == w_tag);
  assign w_idle = (r_state == S_IDLE);

  assign w_sel_word = w_vic_line[{w_wsel, 5'd0} +: WORD_W];

  assign p1_stall_o = !w_idle | (w_req & !w_hit);
  // A combined read+write is a store, so it returns no load data.
  assign p1_data_o  = (w_idle & w_hit & p1_MemRead_i & !p1_MemWrite_i) ? w_sel_word : '0;

  // Single write port: store hits merge a word, REFILL installs the line.
  assign w_wr_fill = (r_state == S_REFILL);
  assign w_wr_en   = (w_idle & w_hit & p1_MemWrite_i) | w_wr_fill;

  dcache_sram u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (w_idx),
    .rd_valid_o (w_vic_valid),
    .rd_dirty_o (w_vic_dirty),
    .rd_tag_o   (w_vic_tag),
    .rd_line_o  (w_vic_line),
    .wr_en_i    (w_wr_en),
    .wr_fill_i  (w_wr_fill),
    .wr_idx_i   (w_idx),
    .wr_tag_i   (w_tag),
    .wr_line_i  (r_line_buf),
    .wr_wsel_i  (w_wsel),
    .wr_word_i  (p1_data_i)
  );

  // Memory-port outputs are registered and change only on state transitions,
  // which keeps them stable for the whole life of each request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_line_buf   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && !w_hit) begin
            r_mem_enable <= 1'b1;
            if (w_vic_valid && w_vic_dirty) begin
              r_state     <= S_WRITEBACK;
              r_mem_write <= 1'b1;
              r_mem_addr  <= line_addr(w_vic_tag, w_idx);
              r_mem_data  <= w_vic_line;
            end else begin
              r_state     <= S_ALLOCATE;
              r_mem_write <= 1'b0;
              r_mem_addr  <= line_addr(w_tag, w_idx);
            end
          end
        end
        S_WRITEBACK: begin
          if (mem.ack) begin
            r_state     <= S_ALLOCATE;
            r_mem_write <= 1'b0;
            r_mem_addr  <= line_addr(w_tag, w_idx);
          end
        end
        S_ALLOCATE: begin
          if (mem.ack) begin
            r_state      <= S_REFILL;
            r_mem_enable <= 1'b0;
            r_line_buf   <= mem.rdata;
          end
        end
        S_REFILL: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.enable  = r_mem_enable;
  assign mem.write   = r_mem_write;
  assign mem.addr    = r_mem_addr;
  assign mem.wdata   = r_mem_data;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;
  import dcache_pkg::*;

  localparam int L        = 10;
  localparam int MAX_WAIT = 1000;
  localparam int N_RAND   = 200;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_i;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [31:0] p1_data;
  logic        stall;
  state_t      dbg_state;

  dcache_mem_if mem();

  dcache_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .p1_MemRead_i (rd),
    .p1_MemWrite_i(wr),
    .p1_addr_i    (addr),
    .p1_data_i    (wdata),
    .p1_data_o    (p1_data),
    .p1_stall_o   (stall),
    .dbg_state_o  (dbg_state),
    .mem          (mem)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory views ----------------
  // backing: what off-chip memory holds; golden: what the CPU should observe.
  logic [31:0] backing [logic [31:0]];
  logic [31:0] golden  [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] back_rd(input logic [31:0] a);
    if (backing.exists(a)) return backing[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    if (golden.exists(a)) return golden[a];
    return back_rd(a);
  endfunction

  // ---------------- memory responder ----------------
  int              mem_lat = L;
  bit              model_on = 1'b1;
  bit              model_ack = 1'b0;
  bit              stray_ack = 1'b0;
  logic [LINE_W-1:0] model_rdata = '0;
  int              mem_cnt = 0;
  logic [31:0]     last_wb_addr = '0;
  logic [LINE_W-1:0] last_wb_line = '0;
  logic [31:0]     last_fetch_addr = '0;

  assign mem.ack   = model_ack | stray_ack;
  assign mem.rdata = model_rdata;

  // Acks in the mem_lat-th cycle that a request is seen.
  always @(negedge clk) begin
    if (!rst_i || !model_on) begin
      model_ack = 1'b0;
      mem_cnt   = 0;
    end else begin
      if (model_ack) begin
        model_ack = 1'b0;
        mem_cnt   = 0;
      end
      if (mem.enable) begin
        mem_cnt++;
        if (mem_cnt == mem_lat) begin
          if (mem.write) begin
            for (int w = 0; w < 8; w++) backing[mem.addr + 32'(4*w)] = mem.wdata[32*w +: 32];
            last_wb_addr = mem.addr;
            last_wb_line = mem.wdata;
          end else begin
            for (int w = 0; w < 8; w++) model_rdata[32*w +: 32] = back_rd(mem.addr + 32'(4*w));
            last_fetch_addr = mem.addr;
          end
          model_ack = 1'b1;
        end
      end
    end
  end

  // ---------------- reference cache model ----------------
  bit          ref_valid [NUM_LINES];
  bit          ref_dirty [NUM_LINES];
  logic [31:0] ref_line  [NUM_LINES];

  function automatic void ref_reset();
    for (int i = 0; i < NUM_LINES; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
      ref_line[i]  = '0;
    end
    golden.delete();
  endfunction

  function automatic void ref_access(input bit wr_i, input logic [31:0] a, input logic [31:0] d,
                                     input int lat, output int exp_stall, output logic [31:0] exp_data,
                                     output bit evict, output logic [31:0] victim);
    int idx;
    logic [31:0] la;
    idx = int'((a / 32) % NUM_LINES);
    la  = a & ~32'h1F;
    exp_stall = 0;
    evict     = 1'b0;
    victim    = '0;
    exp_data  = '0;
    if (!(ref_valid[idx] && ref_line[idx] == la)) begin
      if (ref_valid[idx] && ref_dirty[idx]) begin
        exp_stall = 2*lat + 2;
        evict     = 1'b1;
        victim    = ref_line[idx];
      end else begin
        exp_stall = lat + 2;
      end
      ref_valid[idx] = 1'b1;
      ref_line[idx]  = la;
      ref_dirty[idx] = 1'b0;
    end
    if (wr_i) begin
      golden[a]      = d;
      ref_dirty[idx] = 1'b1;
    end else begin
      exp_data = gold_rd(a);
    end
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; holds the request until the stall clears,
  // lets the completing edge pass, then drops the request.
  task automatic do_access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                           output int nstall, output logic [31:0] data);
    bit done;
    rd = r; wr = w; addr = a; wdata = d;
    nstall = 0; data = '0; done = 1'b0;
    for (int c = 0; c < MAX_WAIT; c++) begin
      @(negedge clk);
      if (!stall) begin
        data = p1_data;
        done = 1'b1;
        break;
      end
      nstall++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: addr %0h still stalled after %0d cycles, required completion", a, MAX_WAIT);
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          exp_stall;
    logic [31:0] exp_data;
    bit          chk_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          ns, es;
    logic [31:0] got, ed, victim, ra, rdat;
    bit          ev;
    int          op;

    vecs[0] = '{1, 0, 32'h0000_0040, 32'h0,          L + 2,   init_word(32'h40),  1};
    vecs[1] = '{0, 1, 32'h0000_0044, 32'hDEAD_BEEF,  0,       32'h0,              0};
    vecs[2] = '{1, 0, 32'h0000_0044, 32'h0,          0,       32'hDEAD_BEEF,      1};
    vecs[3] = '{1, 0, 32'h0000_0444, 32'h0,          2*L + 2, init_word(32'h444), 1};
    vecs[4] = '{1, 0, 32'h0000_0044, 32'h0,          L + 2,   32'hDEAD_BEEF,      1};
    vecs[5] = '{1, 1, 32'h0000_0048, 32'h1234_5678,  0,       32'h0,              0};
    vecs[6] = '{1, 0, 32'h0000_0048, 32'h0,          0,       32'h1234_5678,      1};
    vecs[7] = '{1, 0, 32'h0000_0448, 32'h0,          2*L + 2, init_word(32'h448), 1};

    rd = 0; wr = 0; addr = '0; wdata = '0;
    rst_i = 1'b0;
    ref_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_enable", mem.enable, 1'b0);
    chk("reset_mem_write",  mem.write,  1'b0);
    chk("reset_mem_addr",   mem.addr,   32'h0);
    chk("reset_mem_data",   mem.wdata,  256'h0);
    chk("reset_stall",      stall,      1'b0);
    chk("reset_p1_data",    p1_data,    32'h0);
    chk("reset_state",      dbg_state,  S_IDLE);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;

    mem_lat = L;
    for (int i = 0; i < 8; i++) begin
      ref_access(vecs[i].wr, vecs[i].addr, vecs[i].data, L, es, ed, ev, victim);
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, ns, got);
      chk($sformatf("vec%0d_stall", i), 32'(ns), 32'(vecs[i].exp_stall));
      if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
      if (i == 3) begin
        chk("vec3_wb_addr",    last_wb_addr,        32'h40);
        chk("vec3_wb_word1",   last_wb_line[63:32], 32'hDEAD_BEEF);
        chk("vec3_fetch_addr", last_fetch_addr,     32'h440);
      end
      if (i == 7) begin
        chk("vec7_wb_addr",  last_wb_addr,        32'h40);
        chk("vec7_wb_word2", last_wb_line[95:64], 32'h1234_5678);
      end
    end

    // Back-to-back hits over every word of the resident line 0x440.
    for (int w = 0; w < 8; w++) begin
      ra = 32'h440 + 32'(4*w);
      ref_access(1'b0, ra, 32'h0, L, es, ed, ev, victim);
      do_access(1'b1, 1'b0, ra, 32'h0, ns, got);
      chk($sformatf("b2b%0d_stall", w), 32'(ns), 32'h0);
      chk($sformatf("b2b%0d_data", w),  got,     init_word(ra));
    end

    // Reset while a fetch is outstanding; a late ack must be ignored.
    model_on = 1'b0;
    rd = 1'b1; addr = 32'h0000_0840;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dbg_state == S_ALLOCATE) break;
    end
    chk("rst_alloc_state",  dbg_state,  S_ALLOCATE);
    chk("rst_alloc_enable", mem.enable, 1'b1);
    chk("rst_alloc_addr",   mem.addr,   32'h840);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_async_enable", mem.enable, 1'b0);
    chk("rst_async_state",  dbg_state,  S_IDLE);
    rd = 1'b0;
    ref_reset();
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk); stray_ack = 1'b1;
    @(negedge clk); stray_ack = 1'b0;
    chk("stray_ack_state",  dbg_state,  S_IDLE);
    chk("stray_ack_enable", mem.enable, 1'b0);
    @(negedge clk);
    chk("stray_ack_state2", dbg_state,  S_IDLE);
    model_on = 1'b1;
    @(posedge clk); #1;
    ref_access(1'b0, 32'h40, 32'h0, L, es, ed, ev, victim);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, ns, got);
    chk("post_rst_stall", 32'(ns), 32'(L + 2));
    chk("post_rst_data",  got,     init_word(32'h40));

    // Randomized traffic against the reference model.
    for (int n = 0; n < N_RAND; n++) begin
      mem_lat = int'($urandom_range(1, 6));
      ra   = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5) |
             (32'($urandom_range(0, 7)) << 2);
      rdat = $urandom;
      op   = int'($urandom_range(0, 2));
      ref_access(op != 0, ra, rdat, mem_lat, es, ed, ev, victim);
      if (op == 0) exp_q.push_back(ed);
      do_access(op != 1, op != 0, ra, rdat, ns, got);
      chk($sformatf("rand%0d_stall", n), 32'(ns), 32'(es));
      if (op == 0) chk($sformatf("rand%0d_data", n), got, exp_q.pop_front());
      if (ev) begin
        for (int w = 0; w < 8; w++) begin
          if (golden.exists(victim + 32'(4*w)))
            chk($sformatf("rand%0d_wb_word%0d", n, w), back_rd(victim + 32'(4*w)),
                golden[victim + 32'(4*w)]);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
